// File: rtl/masked_sbox_layer_ctrl.sv
// masked_sbox_layer_ctrl
//   Serialized 5-share threshold-implementation PRINCE S-box layer. The
//   masked state is streamed one nibble per cycle through a single
//   masked_sbox, followed by a share-wise register stage, and reassembled
//   into a 5-share result.
//
// masked_sbox
//   Combinational 5-share direct sharing of the PRINCE S-box.
//   v..z        : input shares (4 bits each)
//   out_v..out_z: output shares; component j never depends on input share j
//
// masked_sbox_layer_ctrl ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : request, sampled only in IDLE
//   in_v..in_z        : input shares, W = 4*NIBBLES bits each
//   busy              : high while an operation is in RUN or FLUSH
//   done              : one-cycle pulse when out_* is updated
//   out_v..out_z      : registered output shares, held until next done
//   NIBBLES must be at least 2.

module masked_sbox (
  input  logic [3:0] v,
  input  logic [3:0] w,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [3:0] z,
  output logic [3:0] out_v,
  output logic [3:0] out_w,
  output logic [3:0] out_x,
  output logic [3:0] out_y,
  output logic [3:0] out_z
);

  // Entry i of the S-box lives in bits [4i+3:4i].
  localparam logic [63:0] SBOX_TABLE = 64'h4D5E_0876_19CA_23FB;

  // Algebraic normal form of each output bit: coefficient of monomial m for
  // bit b sits at bit 16*b+m.
  function automatic logic [63:0] sbox_anf();
    logic [15:0] t;
    logic [63:0] a;
    a = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      for (int unsigned xv = 0; xv < 16; xv++) begin
        t[4'(xv)] = SBOX_TABLE[6'(4 * xv + b)];
      end
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned xv = 0; xv < 16; xv++) begin
          if (((xv >> i) & 32'd1) != 32'd0) begin
            t[4'(xv)] = t[4'(xv)] ^ t[4'(xv ^ (32'd1 << i))];
          end
        end
      end
      a[6'(16 * b) +: 16] = t;
    end
    return a;
  endfunction

  localparam logic [63:0] ANF = sbox_anf();

  // Direct sharing: every monomial is expanded over all share combinations
  // of its variables, and each product term is given to the lowest-numbered
  // component whose own share does not appear in it. That keeps every
  // component independent of its own input share (non-completeness), and
  // the components still sum to the unmasked S-box.
  function automatic logic [3:0] tf_share(input int unsigned j, input logic [19:0] s);
    logic [3:0]  r;
    logic        term;
    logic [4:0]  used;
    int unsigned owner;
    r = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      for (int unsigned m = 0; m < 16; m++) begin
        if (ANF[6'(16 * b + m)]) begin
          for (int unsigned a0 = 0; a0 < (((m & 32'd1) != 0) ? 32'd5 : 32'd1); a0++) begin
            for (int unsigned a1 = 0; a1 < (((m & 32'd2) != 0) ? 32'd5 : 32'd1); a1++) begin
              for (int unsigned a2 = 0; a2 < (((m & 32'd4) != 0) ? 32'd5 : 32'd1); a2++) begin
                for (int unsigned a3 = 0; a3 < (((m & 32'd8) != 0) ? 32'd5 : 32'd1); a3++) begin
                  term = 1'b1;
                  used = '0;
                  if ((m & 32'd1) != 0) begin
                    term = term & s[5'(4 * a0)];
                    used[3'(a0)] = 1'b1;
                  end
                  if ((m & 32'd2) != 0) begin
                    term = term & s[5'(4 * a1 + 1)];
                    used[3'(a1)] = 1'b1;
                  end
                  if ((m & 32'd4) != 0) begin
                    term = term & s[5'(4 * a2 + 2)];
                    used[3'(a2)] = 1'b1;
                  end
                  if ((m & 32'd8) != 0) begin
                    term = term & s[5'(4 * a3 + 3)];
                    used[3'(a3)] = 1'b1;
                  end
                  owner = 0;
                  for (int unsigned k = 5; k > 0; k--) begin
                    if (!used[3'(k - 1)]) owner = k - 1;
                  end
                  if (owner == j) r[2'(b)] = r[2'(b)] ^ term;
                end
              end
            end
          end
        end
      end
    end
    return r;
  endfunction

  logic [19:0] shares;
  assign shares = {z, y, x, w, v};

  assign out_v = tf_share(0, shares);
  assign out_w = tf_share(1, shares);
  assign out_x = tf_share(2, shares);
  assign out_y = tf_share(3, shares);
  assign out_z = tf_share(4, shares);

endmodule

module masked_sbox_layer_ctrl #(
  parameter int unsigned NIBBLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] in_v,
  input  logic [4*NIBBLES-1:0] in_w,
  input  logic [4*NIBBLES-1:0] in_x,
  input  logic [4*NIBBLES-1:0] in_y,
  input  logic [4*NIBBLES-1:0] in_z,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] out_v,
  output logic [4*NIBBLES-1:0] out_w,
  output logic [4*NIBBLES-1:0] out_x,
  output logic [4*NIBBLES-1:0] out_y,
  output logic [4*NIBBLES-1:0] out_z
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state, state_next;
  logic [4:0][W-1:0]   s_q;
  logic [4:0][3:0]     r_q;
  logic                rv;
  logic [4:0][W-1:0]   o_q;
  logic [4:0][W-1:0]   out_q;
  logic [CW-1:0]       cnt;
  logic [4:0][3:0]     sb;

  masked_sbox u_sbox (
    .v     (s_q[0][3:0]),
    .w     (s_q[1][3:0]),
    .x     (s_q[2][3:0]),
    .y     (s_q[3][3:0]),
    .z     (s_q[4][3:0]),
    .out_v (sb[0]),
    .out_w (sb[1]),
    .out_x (sb[2]),
    .out_y (sb[3]),
    .out_z (sb[4])
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == CNT_LAST) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      s_q   <= '0;
      r_q   <= '0;
      rv    <= 1'b0;
      o_q   <= '0;
      out_q <= '0;
      cnt   <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FLUSH);
      if (rv) begin
        for (int unsigned k = 0; k < 5; k++) begin
          o_q[3'(k)] <= {r_q[3'(k)], o_q[3'(k)][W-1:4]};
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            s_q <= {in_z, in_y, in_x, in_w, in_v};
            cnt <= '0;
          end
        end
        RUN: begin
          r_q <= sb;
          rv  <= 1'b1;
          for (int unsigned k = 0; k < 5; k++) begin
            s_q[3'(k)] <= s_q[3'(k)] >> 4;
          end
          cnt <= cnt + 1'b1;
        end
        FLUSH: begin
          // The last nibble joins O on this same edge, so publish the
          // shifted value rather than the current register contents.
          for (int unsigned k = 0; k < 5; k++) begin
            out_q[3'(k)] <= {r_q[3'(k)], o_q[3'(k)][W-1:4]};
          end
          rv <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_v = out_q[0];
  assign out_w = out_q[1];
  assign out_x = out_q[2];
  assign out_y = out_q[3];
  assign out_z = out_q[4];

endmodule

// File: tb/tb_masked_sbox_layer_ctrl.sv
module tb_masked_sbox_layer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] in_v, in_w, in_x, in_y, in_z;
  logic        busy, done;
  logic [63:0] out_v, out_w, out_x, out_y, out_z;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc = 0;

  typedef struct {
    string       name;
    logic [63:0] value;
    logic [63:0] expected;
  } vec_t;

  vec_t vecs [5];

  masked_sbox_layer_ctrl #(.NIBBLES(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in_v  (in_v),
    .in_w  (in_w),
    .in_x  (in_x),
    .in_y  (in_y),
    .in_z  (in_z),
    .busy  (busy),
    .done  (done),
    .out_v (out_v),
    .out_w (out_w),
    .out_x (out_x),
    .out_y (out_y),
    .out_z (out_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] out_xor();
    return out_v ^ out_w ^ out_x ^ out_y ^ out_z;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Called away from a clock edge; returns just after the accepting edge.
  task automatic start_op(input logic [63:0] value);
    logic [63:0] mv, mw, mx, my;
    mv = rand64(); mw = rand64(); mx = rand64(); my = rand64();
    in_v = mv; in_w = mw; in_x = mx; in_y = my;
    in_z = value ^ mv ^ mw ^ mx ^ my;
    start = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, input logic [63:0] hold_val,
                           output bit hold_ok, output bit busy_ok);
    seen = 1'b0; hold_ok = 1'b1; busy_ok = 1'b1;
    if (!busy) busy_ok = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        if (out_xor() !== hold_val) hold_ok = 1'b0;
      end
    end
  endtask

  task automatic run_check(input string name, input logic [63:0] value, input logic [63:0] expected);
    bit seen, hold_ok, busy_ok;
    start_op(value);
    wait_done(seen, '0, hold_ok, busy_ok);
    check({name, " done_seen"}, 64'(seen), 64'd1);
    check({name, " latency"}, 64'(cyc - accept_cyc), 64'd17);
    check({name, " busy_while_running"}, 64'(busy_ok), 64'd1);
    check({name, " busy_low_at_done"}, 64'(busy), 64'd0);
    check({name, " result"}, out_xor(), expected);
    @(posedge clk); #1;
    check({name, " done_single_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit seen, seen2, hold_ok, busy_ok, flag;
    int d1, extra;

    vecs[0] = '{"zero",     64'h0000_0000_0000_0000, 64'hBBBB_BBBB_BBBB_BBBB};
    vecs[1] = '{"count",    64'hFEDC_BA98_7654_3210, 64'h4D5E_0876_19CA_23FB};
    vecs[2] = '{"revcount", 64'h0123_4567_89AB_CDEF, 64'hBF32_AC91_6780_E5D4};
    vecs[3] = '{"ones",     64'hFFFF_FFFF_FFFF_FFFF, 64'h4444_4444_4444_4444};
    vecs[4] = '{"mixed",    64'h5555_AAAA_0000_FFFF, 64'hCCCC_8888_BBBB_4444};

    rst = 1'b1; start = 1'b0;
    in_v = '0; in_w = '0; in_x = '0; in_y = '0; in_z = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out_or", out_v | out_w | out_x | out_y | out_z, 64'd0);

    flag = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (busy || done) flag = 1'b1;
    end
    check("idle quiet", 64'(flag), 64'd0);

    for (int i = 0; i < 5; i++) run_check(vecs[i].name, vecs[i].value, vecs[i].expected);

    for (int i = 0; i < 20; i++) run_check("random_masks", vecs[1].value, vecs[1].expected);

    // Back-to-back: second start issued in the done cycle.
    start_op(vecs[2].value);
    wait_done(seen, '0, hold_ok, busy_ok);
    check("b2b first_done", 64'(seen), 64'd1);
    d1 = cyc;
    check("b2b first_result", out_xor(), vecs[2].expected);
    start_op(vecs[1].value);
    wait_done(seen2, vecs[2].expected, hold_ok, busy_ok);
    check("b2b second_done", 64'(seen2), 64'd1);
    check("b2b period", 64'(cyc - d1), 64'd18);
    check("b2b first_held", 64'(hold_ok), 64'd1);
    check("b2b second_result", out_xor(), vecs[1].expected);
    @(posedge clk); #1;

    // Start and input changes while busy are ignored.
    start_op(vecs[4].value);
    repeat (4) @(posedge clk);
    #1;
    in_v = rand64(); in_w = rand64(); in_x = rand64(); in_y = rand64(); in_z = rand64();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_v = rand64(); in_w = rand64(); in_x = rand64(); in_y = rand64(); in_z = rand64();
    wait_done(seen, '0, hold_ok, busy_ok);
    check("ignored_start done_seen", 64'(seen), 64'd1);
    check("ignored_start latency", 64'(cyc - accept_cyc), 64'd17);
    check("ignored_start result", out_xor(), vecs[4].expected);
    extra = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("ignored_start extra_done", 64'(extra), 64'd0);

    // Reset when cnt = 7 (after the seventh RUN edge).
    start_op(vecs[3].value);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset out_or", out_v | out_w | out_x | out_y | out_z, 64'd0);
    extra = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("midreset no_activity", 64'(extra), 64'd0);
    run_check("after_reset", vecs[1].value, vecs[1].expected);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
